pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Run-control sequencer for the 16-bit single-cycle processor. It owns the 3-bit `pc` bus and the processor reset, and steps the program from address 0. Each pc update uses the current instruction's `sig_jump`, `sig_branch` and `zero_flag`. It supports free-run, single-step and stop/restart, counts retired instructions, and flags program completion to the test harness or host.

## Interface
- `LAST_PC`, 3'd7: address of the final instruction; sequential advance past it ends the program.
- `MAX_INSTR`, 8'd200: watchdog instruction limit; used only when `SEQ_WATCHDOG_EN` is defined.
- `clk` input 1: single clock, all state updates on rising edge.
- `rst` input 1: synchronous, active-low reset.
- `start` input 1: begin or restart program (level-sampled).
- `stop` input 1: halt execution.
- `single_step` input 1: 1 = advance only on `step`; 0 = free-run.
- `step` input 1: advance one instruction when `single_step`=1.
- `sig_jump` input 1: current instruction is a jump.
- `sig_branch` input 1: current instruction is a branch.
- `zero_flag` input 1: ALU zero result of current instruction.
- `target` input 3: jump address / branch offset (instruction[2:0]).
- `pc` output 3: instruction address to processor.
- `proc_rst` output 1: processor reset, active-high.
- `running` output 1: high in RUN.
- `halted` output 1: high in HALT.
- `done` output 1: one-cycle pulse on normal completion.
- `timeout` output 1: sticky watchdog-expiry flag.
- `instr_count` output 8: retired-instruction count, saturating.

## Operation
- States:
  - IDLE: after reset.
  - CLEAR: one cycle.
  - RUN.
  - HALT.
- IDLE: `pc`=0, `proc_rst`=1. `start`=1 moves to CLEAR.
- CLEAR: `pc`=0, `proc_rst`=1, `instr_count` cleared. Moves unconditionally to RUN.
- RUN: `proc_rst`=0. An *advance* occurs on a cycle where `single_step`=0, or where `single_step`=1 and `step`=1.
- Next pc on advance, in priority order:
  - `sig_jump`=1: `target`.
  - else `sig_branch`=1 and `zero_flag`=1: `pc + 1 + target`, 3-bit modulo 8, wrap allowed.
  - else `pc + 1`.
- Completion: an advance at `pc`==`LAST_PC` with no jump and no taken branch goes to HALT. It pulses `done` and leaves `pc` unchanged. Sequential `pc` never wraps 7→0.
- Every advance, including the completing one, increments `instr_count`. The count saturates at 255.
- `stop`=1 in RUN: go to HALT at that edge with no advance. `stop` beats `step` and completion.
- HALT: `pc` holds, `proc_rst`=0, the processor stays quiescent on the held pc. `start`=1 moves to CLEAR (restart). `step` and `stop` are ignored.
- `start` is ignored in RUN and CLEAR.
- `stop` in IDLE or CLEAR is ignored.

## Timing
- Reset (`rst`=0 at a rising edge) puts every output in a known state:
  - `pc`=0, `proc_rst`=1, `running`=0, `halted`=0, `done`=0, `timeout`=0, `instr_count`=0, state IDLE.
- Reset has priority over all inputs, including mid-RUN.
- All outputs are registered.
- `pc` changes one cycle after the sampling edge. The processor is combinational from `pc`, so the flags sampled at edge N belong to the instruction at the `pc` driven during cycle N.
- Latency: the first instruction (pc=0) executes in the first RUN cycle, two edges after `start` is sampled in IDLE.
- `done` is high for exactly the single cycle after the HALT transition.
- The control inputs (`sig_jump`, `sig_branch`, `zero_flag`, `target`) are ignored outside RUN and on non-advance cycles.

## Configuration
- `SEQ_WATCHDOG_EN` defined:
  - An advance that brings `instr_count` to `MAX_INSTR` forces HALT (no `done`) and sets `timeout`.
  - `timeout` clears only on reset or CLEAR.
  - Normal completion on that same advance takes precedence: `done` pulses and `timeout` stays 0.
- `SEQ_WATCHDOG_EN` undefined: no limit; `timeout` is tied 0 and `MAX_INSTR` is unused.

## Test plan
- Reset, then `start` with straight-line flags (all 0), `single_step`=0 → `pc` goes 0,1,…,7 on consecutive cycles, then HALT. `done` pulses once and `instr_count`=8.
- At `pc`=6, `sig_branch`=1, `zero_flag`=1, `target`=3 → next `pc`=2 (wrap). With `zero_flag`=0 → next `pc`=7.
- At `pc`=4, `sig_jump`=1 and `sig_branch`=1 together, `target`=1 → next `pc`=1 (jump priority).
- `single_step`=1 with `step` pulsed on 3 non-adjacent cycles → `pc` 0→1→2→3 only on those cycles. Asserting `stop` and `step` together at `pc`=3 → HALT with `pc`=3 and no `done`.
- Drive `rst`=0 in RUN at `pc`=5 → next cycle `pc`=0, `proc_rst`=1, state IDLE. Then `start` in HALT after a run → CLEAR, `instr_count`=0, restart from 0.
- With `SEQ_WATCHDOG_EN` and `MAX_INSTR`=10, a jump loop (`target`=0 at `pc`=2) → HALT after the 10th advance with `timeout`=1 and `done` never asserted.

Source files
------------

// File: rtl/pc_sequencer.sv
// Run-control sequencer for the 16-bit single-cycle processor: owns pc and processor reset.
// Optional instruction watchdog enabled by defining SEQ_WATCHDOG_EN.
module pc_sequencer #(
   parameter logic [2:0] LAST_PC = 3'd7
`ifdef SEQ_WATCHDOG_EN
   , parameter logic [7:0] MAX_INSTR = 8'd200
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stop,
   input  logic       single_step,
   input  logic       step,
   input  logic       sig_jump,
   input  logic       sig_branch,
   input  logic       zero_flag,
   input  logic [2:0] target,
   output logic [2:0] pc,
   output logic       proc_rst,
   output logic       running,
   output logic       halted,
   output logic       done,
   output logic       timeout,
   output logic [7:0] instr_count
);

   localparam int unsigned PC_W  = 3;
   localparam int unsigned CNT_W = 8;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CLEAR = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_HALT  = 2'd3;

   logic [1:0]       state;
   logic [1:0]       state_next;
   logic [PC_W-1:0]  pc_next;
   logic [PC_W-1:0]  pc_seq;
   logic [PC_W-1:0]  pc_branch;
   logic [CNT_W-1:0] count_next;
   logic [CNT_W-1:0] count_inc;
   logic             done_next;
   logic             advance;
   logic             branch_taken;
   logic             completing;
`ifdef SEQ_WATCHDOG_EN
   logic             timeout_next;
   logic             wd_hit;
`endif

   // Advance qualification, next-pc candidates and saturating count.
   always_comb begin
      advance      = (state == S_RUN) && !stop && (!single_step || step);
      branch_taken = sig_branch && zero_flag;
      pc_seq       = pc + PC_W'(1);
      pc_branch    = pc + PC_W'(1) + target;
      completing   = advance && !sig_jump && !branch_taken && (pc == LAST_PC);
      count_inc    = (instr_count == {CNT_W{1'b1}}) ? instr_count
                                                    : instr_count + CNT_W'(1);
`ifdef SEQ_WATCHDOG_EN
      // Normal completion on the same advance wins over the watchdog.
      wd_hit       = advance && !completing && (count_inc == MAX_INSTR)
                     && (instr_count != MAX_INSTR);
`endif
   end

   // Next-state and next-output logic.
   always_comb begin
      state_next   = state;
      pc_next      = pc;
      count_next   = instr_count;
      done_next    = 1'b0;
`ifdef SEQ_WATCHDOG_EN
      timeout_next = timeout;
`endif
      case (state)
         S_IDLE: begin
            pc_next = '0;
            if (start) begin
               state_next   = S_CLEAR;
               count_next   = '0;
`ifdef SEQ_WATCHDOG_EN
               timeout_next = 1'b0;
`endif
            end
         end
         S_CLEAR: begin
            pc_next      = '0;
            count_next   = '0;
            state_next   = S_RUN;
`ifdef SEQ_WATCHDOG_EN
            timeout_next = 1'b0;
`endif
         end
         S_RUN: begin
            if (stop) begin
               state_next = S_HALT;
            end else if (advance) begin
               count_next = count_inc;
               if (completing) begin
                  state_next = S_HALT;
                  done_next  = 1'b1;
               end else if (sig_jump) begin
                  pc_next = target;
               end else if (branch_taken) begin
                  pc_next = pc_branch;
               end else begin
                  pc_next = pc_seq;
               end
`ifdef SEQ_WATCHDOG_EN
               if (wd_hit) begin
                  state_next   = S_HALT;
                  timeout_next = 1'b1;
               end
`endif
            end
         end
         S_HALT: begin
            if (start) begin
               state_next   = S_CLEAR;
               pc_next      = '0;
               count_next   = '0;
`ifdef SEQ_WATCHDOG_EN
               timeout_next = 1'b0;
`endif
            end
         end
         default: begin
            state_next = S_IDLE;
            pc_next    = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pc          <= '0;
         instr_count <= '0;
         done        <= 1'b0;
         proc_rst    <= 1'b1;
         running     <= 1'b0;
         halted      <= 1'b0;
      end else begin
         pc          <= pc_next;
         instr_count <= count_next;
         done        <= done_next;
         proc_rst    <= (state_next == S_IDLE) || (state_next == S_CLEAR);
         running     <= (state_next == S_RUN);
         halted      <= (state_next == S_HALT);
      end
   end

`ifdef SEQ_WATCHDOG_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         timeout <= 1'b0;
      end else begin
         timeout <= timeout_next;
      end
   end
`else
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer plus hand-written multi-cycle sequences.
module tb_pc_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       start, stop, single_step, step;
   logic       sig_jump, sig_branch, zero_flag;
   logic [2:0] target;
   logic [2:0] pc;
   logic       proc_rst, running, halted, done, timeout;
   logic [7:0] instr_count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pc_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop),
      .single_step(single_step), .step(step), .sig_jump(sig_jump),
      .sig_branch(sig_branch), .zero_flag(zero_flag), .target(target),
      .pc(pc), .proc_rst(proc_rst), .running(running), .halted(halted),
      .done(done), .timeout(timeout), .instr_count(instr_count)
   );

`ifdef SEQ_WATCHDOG_EN
   logic [2:0] wd_pc;
   logic       wd_proc_rst, wd_running, wd_halted, wd_done, wd_timeout;
   logic [7:0] wd_count;

   pc_sequencer #(.MAX_INSTR(8'd10)) dut_wd (
      .clk(clk), .rst(rst), .start(start), .stop(stop),
      .single_step(single_step), .step(step), .sig_jump(sig_jump),
      .sig_branch(sig_branch), .zero_flag(zero_flag), .target(target),
      .pc(wd_pc), .proc_rst(wd_proc_rst), .running(wd_running), .halted(wd_halted),
      .done(wd_done), .timeout(wd_timeout), .instr_count(wd_count)
   );
`endif

   typedef struct {
      logic       start, stop, ss, step, jmp, br, z;
      logic [2:0] tgt;
      logic [2:0] e_pc;
      logic       e_prst, e_run, e_halt, e_done;
      logic [7:0] e_cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic st, input logic sp, input logic ss, input logic stp,
                               input logic j, input logic b, input logic z, input logic [2:0] t,
                               input logic [2:0] epc, input logic eprst, input logic erun,
                               input logic ehalt, input logic edone, input logic [7:0] ecnt);
      vec_t v;
      v.start = st; v.stop = sp; v.ss = ss; v.step = stp;
      v.jmp = j; v.br = b; v.z = z; v.tgt = t;
      v.e_pc = epc; v.e_prst = eprst; v.e_run = erun; v.e_halt = ehalt;
      v.e_done = edone; v.e_cnt = ecnt;
      return v;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      start = 0; stop = 0; single_step = 0; step = 0;
      sig_jump = 0; sig_branch = 0; zero_flag = 0; target = 3'd0;
   endtask

   task automatic chk_all(input string nm, input int epc, input int eprst, input int erun,
                          input int ehalt, input int edone, input int ecnt);
      chk({nm, " pc"}, int'(pc), epc);
      chk({nm, " proc_rst"}, int'(proc_rst), eprst);
      chk({nm, " running"}, int'(running), erun);
      chk({nm, " halted"}, int'(halted), ehalt);
      chk({nm, " done"}, int'(done), edone);
      chk({nm, " count"}, int'(instr_count), ecnt);
      chk({nm, " timeout"}, int'(timeout), 0);
   endtask

   initial begin
      // stop in IDLE ignored, then start -> CLEAR -> RUN (start ignored in CLEAR)
      vecs.push_back(mk(0,1,0,0, 0,0,0,3'd0, 3'd0,1,0,0,0,8'd0));
      vecs.push_back(mk(1,0,0,0, 0,0,0,3'd0, 3'd0,1,0,0,0,8'd0));
      vecs.push_back(mk(1,0,0,0, 0,0,0,3'd0, 3'd0,0,1,0,0,8'd0));
      for (int i = 1; i <= 7; i++)
         vecs.push_back(mk(0,0,0,0, 0,0,0,3'd0, 3'(i),0,1,0,0,8'(i)));
      vecs.push_back(mk(0,0,0,0, 0,0,0,3'd0, 3'd7,0,0,1,1,8'd8));
      vecs.push_back(mk(0,1,1,1, 0,0,0,3'd0, 3'd7,0,0,1,0,8'd8));
      // restart from HALT, branch wrap at pc 6, not-taken branch, jump priority
      vecs.push_back(mk(1,0,0,0, 0,0,0,3'd0, 3'd0,1,0,0,0,8'd0));
      vecs.push_back(mk(0,0,0,0, 0,0,0,3'd0, 3'd0,0,1,0,0,8'd0));
      for (int i = 1; i <= 6; i++)
         vecs.push_back(mk(0,0,0,0, 0,0,0,3'd0, 3'(i),0,1,0,0,8'(i)));
      vecs.push_back(mk(0,0,0,0, 0,1,1,3'd3, 3'd2,0,1,0,0,8'd7));
      for (int i = 3; i <= 6; i++)
         vecs.push_back(mk(0,0,0,0, 0,0,0,3'd0, 3'(i),0,1,0,0,8'(i + 5)));
      vecs.push_back(mk(0,0,0,0, 0,1,0,3'd3, 3'd7,0,1,0,0,8'd12));
      vecs.push_back(mk(0,0,0,0, 1,0,0,3'd4, 3'd4,0,1,0,0,8'd13));
      vecs.push_back(mk(0,0,0,0, 1,1,1,3'd1, 3'd1,0,1,0,0,8'd14));
      vecs.push_back(mk(0,1,0,0, 1,0,0,3'd5, 3'd1,0,0,1,0,8'd14));
      vecs.push_back(mk(0,0,1,1, 0,0,0,3'd0, 3'd1,0,0,1,0,8'd14));
      // single-step with non-adjacent step pulses, then stop beats step
      vecs.push_back(mk(1,0,1,0, 0,0,0,3'd0, 3'd0,1,0,0,0,8'd0));
      vecs.push_back(mk(0,0,1,0, 0,0,0,3'd0, 3'd0,0,1,0,0,8'd0));
      vecs.push_back(mk(1,0,1,0, 0,0,0,3'd0, 3'd0,0,1,0,0,8'd0));
      vecs.push_back(mk(0,0,1,1, 0,0,0,3'd0, 3'd1,0,1,0,0,8'd1));
      vecs.push_back(mk(0,0,1,0, 1,0,0,3'd5, 3'd1,0,1,0,0,8'd1));
      vecs.push_back(mk(0,0,1,0, 0,0,0,3'd0, 3'd1,0,1,0,0,8'd1));
      vecs.push_back(mk(0,0,1,1, 0,0,0,3'd0, 3'd2,0,1,0,0,8'd2));
      vecs.push_back(mk(0,0,1,0, 0,0,0,3'd0, 3'd2,0,1,0,0,8'd2));
      vecs.push_back(mk(0,0,1,1, 0,0,0,3'd0, 3'd3,0,1,0,0,8'd3));
      vecs.push_back(mk(0,1,1,1, 0,0,0,3'd0, 3'd3,0,0,1,0,8'd3));
      vecs.push_back(mk(0,0,1,0, 0,0,0,3'd0, 3'd3,0,0,1,0,8'd3));

      clear_inputs();
      rst = 1'b0;
      tick();
      tick();
      chk_all("reset", 0, 1, 0, 0, 0, 0);
      rst = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         start = vecs[i].start; stop = vecs[i].stop;
         single_step = vecs[i].ss; step = vecs[i].step;
         sig_jump = vecs[i].jmp; sig_branch = vecs[i].br;
         zero_flag = vecs[i].z; target = vecs[i].tgt;
         tick();
         chk_all($sformatf("v%0d", i), int'(vecs[i].e_pc), int'(vecs[i].e_prst),
                 int'(vecs[i].e_run), int'(vecs[i].e_halt), int'(vecs[i].e_done),
                 int'(vecs[i].e_cnt));
      end

      // reset mid-RUN at pc 5, then stay in IDLE without start
      clear_inputs();
      start = 1; tick();
      start = 0; tick();
      repeat (5) tick();
      chk_all("pre_rst", 5, 0, 1, 0, 0, 5);
      rst = 1'b0; tick();
      chk_all("mid_rst", 0, 1, 0, 0, 0, 0);
      rst = 1'b1; tick();
      chk_all("post_rst", 0, 1, 0, 0, 0, 0);

`ifndef SEQ_WATCHDOG_EN
      // jump loop on pc 0 saturates the count at 255
      start = 1; tick();
      start = 0; tick();
      sig_jump = 1; target = 3'd0;
      repeat (300) tick();
      chk_all("saturate", 0, 0, 1, 0, 0, 255);
      stop = 1; tick();
      chk_all("sat_stop", 0, 0, 0, 1, 0, 255);
      clear_inputs();
`else
      begin
         bit seen_done = 0;
         bit got_halt  = 0;
         rst = 1'b0; tick();
         rst = 1'b1;
         start = 1; tick();
         start = 0; tick();
         for (int c = 0; c < 30 && !got_halt; c++) begin
            sig_jump = (wd_pc == 3'd2);
            target   = 3'd0;
            tick();
            if (wd_done) seen_done = 1;
            if (wd_halted) got_halt = 1;
         end
         chk("wd halted", int'(got_halt), 1);
         chk("wd count", int'(wd_count), 10);
         chk("wd timeout", int'(wd_timeout), 1);
         chk("wd no done", int'(seen_done), 0);
         clear_inputs();
         tick();
         chk("wd timeout sticky", int'(wd_timeout), 1);
         start = 1; tick();
         start = 0;
         chk("wd timeout clear", int'(wd_timeout), 0);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
